// File: rtl/tick_sched_ctrl.sv
// tick_sched_ctrl: run-time controller for a programmable tick divider.
// Produces registered one-cycle enable ticks every max(div,1) cycles while
// running, with a valid/ready configuration port, start/stop sequencing,
// finite bursts and ratio changes that only take effect on a period boundary.
// Optional feature macro: TICK_SCHED_PHASE_EN (adds cfg_phase, a start-phase
// offset for the first tick of each run).
module tick_sched_ctrl #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8,
  parameter int DEF_DIV = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic [BURST_W-1:0] cfg_burst,
`ifdef TICK_SCHED_PHASE_EN
  input  logic [CNT_W-1:0]   cfg_phase,
`endif
  input  logic               start,
  input  logic               stop,
  output logic               tick,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] tick_count
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_active_div;
  logic [CNT_W-1:0]   r_shadow_div;
  logic               r_pending;
  logic [BURST_W-1:0] r_active_burst;
  logic [BURST_W-1:0] r_shadow_burst;
  logic               r_burst_pend;
  logic               r_tick;
  logic               r_done;
  logic [BURST_W-1:0] r_tick_count;

  logic [CNT_W-1:0]   w_eff_div;
  logic               w_wrap;
  logic               w_xfer;
  logic               w_burst_end;
  logic               w_go;
  logic               w_end;
  logic               w_start_first;
  logic [CNT_W-1:0]   w_start_cnt;

  // Saturating increment for the issued-tick counter.
  function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] v);
    logic [BURST_W-1:0] r;
    r = (&v) ? v : v + 1'b1;
    return r;
  endfunction

  // Ratio 0 behaves as ratio 1 so the period compare never underflows.
  function automatic logic [CNT_W-1:0] eff_of(input logic [CNT_W-1:0] d);
    logic [CNT_W-1:0] r;
    r = (d == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : d;
    return r;
  endfunction

  // Shared decode: effective ratio, wrap point, handshake and burst end.
  always_comb begin
    w_eff_div   = eff_of(r_active_div);
    w_wrap      = (r_count == (w_eff_div - {{(CNT_W-1){1'b0}}, 1'b1}));
    cfg_ready   = (r_state == S_IDLE) || !r_pending;
    w_xfer      = cfg_valid && cfg_ready;
    w_burst_end = r_tick && (r_active_burst != '0) &&
                  (r_tick_count == r_active_burst);
  end

`ifdef TICK_SCHED_PHASE_EN
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] w_start_eff;
  logic [CNT_W-1:0] w_start_ph;

  // Start preload: place the counter so the first wrap lands 'phase' cycles in.
  // A configuration accepted on the start edge is already honoured here.
  always_comb begin
    w_start_eff = eff_of(w_xfer ? cfg_div : r_active_div);
    w_start_ph  = w_xfer ? cfg_phase : r_phase;
    if (w_start_ph >= w_start_eff) begin
      w_start_ph = w_start_eff - {{(CNT_W-1){1'b0}}, 1'b1};
    end
    w_start_first = (w_start_ph == '0);
    w_start_cnt   = w_start_first ? '0 : (w_start_eff - w_start_ph);
  end

  // Phase is captured alongside the ratio on every accepted configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
    end else if (w_xfer) begin
      r_phase <= cfg_phase;
    end
  end
`else
  // Without a phase offset every run ticks on the cycle right after start.
  always_comb begin
    w_start_first = 1'b1;
    w_start_cnt   = '0;
  end
`endif

  // Next-state decode: start only from IDLE, stop or burst end leave RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_state_nxt = S_RUN;
          w_go        = 1'b1;
        end
      end
      S_RUN: begin
        if (stop || w_burst_end) begin
          w_state_nxt = S_IDLE;
          w_end       = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counter, tick/done pulses and active/shadow configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count        <= '0;
      r_active_div   <= CNT_W'(DEF_DIV);
      r_shadow_div   <= '0;
      r_pending      <= 1'b0;
      r_active_burst <= '0;
      r_shadow_burst <= '0;
      r_burst_pend   <= 1'b0;
      r_tick         <= 1'b0;
      r_done         <= 1'b0;
      r_tick_count   <= '0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        // In IDLE a configuration goes straight to the active registers.
        if (w_xfer) begin
          r_active_div   <= cfg_div;
          r_active_burst <= cfg_burst;
        end
        if (w_go) begin
          r_count      <= w_start_cnt;
          r_tick       <= w_start_first;
          r_tick_count <= {{(BURST_W-1){1'b0}}, w_start_first};
        end
      end else if (w_end) begin
        // Leaving RUN: no tick, one done pulse, fold any waiting update in.
        r_done <= 1'b1;
        if (w_xfer) begin
          r_active_div   <= cfg_div;
          r_active_burst <= cfg_burst;
        end else begin
          if (r_pending) begin
            r_active_div <= r_shadow_div;
          end
          if (r_burst_pend) begin
            r_active_burst <= r_shadow_burst;
          end
        end
        r_pending    <= 1'b0;
        r_burst_pend <= 1'b0;
      end else begin
        // While running, new settings wait in the shadow registers.
        if (w_xfer) begin
          r_shadow_div   <= cfg_div;
          r_shadow_burst <= cfg_burst;
          r_pending      <= 1'b1;
          r_burst_pend   <= 1'b1;
        end
        if (w_wrap) begin
          r_count      <= '0;
          r_tick       <= 1'b1;
          r_tick_count <= sat_inc(r_tick_count);
          // Only an update pending before this edge is applied, so the
          // period that just finished was never shortened.
          if (r_pending) begin
            r_active_div <= r_shadow_div;
            r_pending    <= 1'b0;
          end
        end else begin
          r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign tick       = r_tick;
  assign busy       = (r_state == S_RUN);
  assign done       = r_done;
  assign tick_count = r_tick_count;

endmodule

// File: tb/tb_tick_sched_ctrl.sv
// Testbench for tick_sched_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a time-to-next-tick model.
module tb_tick_sched_ctrl;
  localparam int CNT_W   = 16;
  localparam int BURST_W = 8;
  localparam int DEF_DIV = 16;
  localparam int TC_MAX  = (1 << BURST_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_div = '0;
  logic [BURST_W-1:0] cfg_burst = '0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               tick;
  logic               busy;
  logic               done;
  logic [BURST_W-1:0] tick_count;

  tick_sched_ctrl #(.CNT_W(CNT_W), .BURST_W(BURST_W), .DEF_DIV(DEF_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_burst(cfg_burst), .start(start), .stop(stop),
    .tick(tick), .busy(busy), .done(done), .tick_count(tick_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model: run flag, ratios, shadow updates, ticks issued and the
  // number of cycles still to wait before the next tick appears.
  int m_run, m_div, m_burst, m_sdiv, m_pend, m_sburst, m_bpend, m_tc, m_left;
  int e_tick, e_done;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    m_run = 0; m_div = DEF_DIV; m_burst = 0; m_sdiv = 0; m_pend = 0;
    m_sburst = 0; m_bpend = 0; m_tc = 0; m_left = 0; e_tick = 0; e_done = 0;
  endtask

  task automatic model_step();
    int xfer, finish, pend_old;
    xfer = (cfg_valid && (!m_run || !m_pend)) ? 1 : 0;
    pend_old = m_pend;
    if (!m_run) begin
      e_tick = 0; e_done = 0;
      if (xfer != 0) begin m_div = int'(cfg_div); m_burst = int'(cfg_burst); end
      if (start && !stop) begin
        m_run = 1; m_tc = 1; e_tick = 1; m_left = eff(m_div) - 1;
      end
    end else begin
      finish = (stop || (e_tick != 0 && m_burst != 0 && m_tc == m_burst)) ? 1 : 0;
      if (finish != 0) begin
        m_run = 0; e_tick = 0; e_done = 1;
        if (xfer != 0) begin
          m_div = int'(cfg_div); m_burst = int'(cfg_burst);
        end else begin
          if (m_pend != 0) m_div = m_sdiv;
          if (m_bpend != 0) m_burst = m_sburst;
        end
        m_pend = 0; m_bpend = 0;
      end else begin
        e_done = 0;
        if (xfer != 0) begin
          m_sdiv = int'(cfg_div); m_sburst = int'(cfg_burst); m_pend = 1; m_bpend = 1;
        end
        if (m_left == 0) begin
          e_tick = 1;
          if (m_tc < TC_MAX) m_tc++;
          if (pend_old != 0) begin m_div = m_sdiv; m_pend = 0; end
          m_left = eff(m_div) - 1;
        end else begin
          e_tick = 0; m_left--;
        end
      end
    end
  endtask

  // One clock: the model consumes the inputs the DUT samples at this edge,
  // then inputs may change 2 time units later.
  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    #2;
  endtask

  task automatic cfg(input int d, input int b);
    cfg_valid = 1'b1; cfg_div = CNT_W'(d); cfg_burst = BURST_W'(b);
    cyc();
    cfg_valid = 1'b0;
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
        check("m_tick", int'(tick), e_tick);
        check("m_busy", int'(busy), m_run);
        check("m_done", int'(done), e_done);
        check("m_tick_count", int'(tick_count), m_tc);
        check("m_cfg_ready", int'(cfg_ready), (m_run == 0 || m_pend == 0) ? 1 : 0);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) cyc();
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("rst_tick", int'(tick), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_tick_count", int'(tick_count), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);

    // Default ratio 16, continuous: ticks at T+1, T+17, T+33.
    start = 1'b1; cyc(); start = 1'b0;
    check("t1_first_tick", int'(tick), 1);
    check("t1_busy", int'(busy), 1);
    for (int i = 2; i <= 34; i++) begin
      cyc();
      check("t1_tick", int'(tick), (i == 17 || i == 33) ? 1 : 0);
      check("t1_done", int'(done), 0);
    end
    stop = 1'b1; cyc(); stop = 1'b0;
    check("t1_stop_done", int'(done), 1);
    cyc();

    // Burst of 3 at ratio 4: ticks at T+1, T+5, T+9, done at T+10.
    cfg(4, 3);
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      if (i > 1) cyc();
      check("t2_tick", int'(tick), (i == 1 || i == 5 || i == 9) ? 1 : 0);
      check("t2_done", int'(done), (i == 10) ? 1 : 0);
      check("t2_busy", int'(busy), (i <= 9) ? 1 : 0);
    end
    check("t2_tick_count", int'(tick_count), 3);

    // Ratio 8, then 3 accepted mid-period: ticks 1, 9, 12, 15; stop on 18.
    cfg(8, 0);
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      if (i > 1) cyc();
      check("t3_tick", int'(tick), (i == 1 || i == 9 || i == 12 || i == 15) ? 1 : 0);
      check("t3_cfg_ready", int'(cfg_ready), (i < 4 || i >= 9) ? 1 : 0);
      if (i == 3) begin cfg_valid = 1'b1; cfg_div = 16'd3; end
      if (i == 4) cfg_valid = 1'b0;
      if (i == 17) stop = 1'b1;
    end
    cyc(); stop = 1'b0;
    check("t4_stop_no_tick", int'(tick), 0);
    check("t4_stop_done", int'(done), 1);
    check("t4_stop_busy", int'(busy), 0);
    check("t4_stop_count", int'(tick_count), 4);
    cyc();
    check("t4_done_once", int'(done), 0);

    // Ratio 0 ticks every cycle.
    cfg(0, 0);
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) cyc();
      check("t5_div0_tick", int'(tick), 1);
      check("t5_div0_count", int'(tick_count), i);
    end
    stop = 1'b1; cyc(); stop = 1'b0; cyc();
    // Ratio 1 with burst 2: two back-to-back ticks then done.
    cfg(1, 2);
    start = 1'b1; cyc(); start = 1'b0;
    check("t5_div1_tick_a", int'(tick), 1);
    cyc();
    check("t5_div1_tick_b", int'(tick), 1);
    cyc();
    check("t5_div1_done", int'(done), 1);
    check("t5_div1_tick_c", int'(tick), 0);
    cyc();
    // start and stop together in IDLE: nothing happens.
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    check("t5_ss_busy", int'(busy), 0);
    check("t5_ss_done", int'(done), 0);
    check("t5_ss_tick", int'(tick), 0);

    // Asynchronous reset in the middle of a run.
    cfg(5, 0);
    start = 1'b1; cyc(); start = 1'b0;
    repeat (6) cyc();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_tick", int'(tick), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_done", int'(done), 0);
    check("t6_rst_count", int'(tick_count), 0);
    check("t6_rst_ready", int'(cfg_ready), 1);
    repeat (2) cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t6_post_tick", int'(tick), 0);
      check("t6_post_done", int'(done), 0);
    end
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      if (i > 1) cyc();
      check("t6_def_div_tick", int'(tick), (i == 1 || i == 17) ? 1 : 0);
    end
    stop = 1'b1; cyc(); stop = 1'b0; cyc();

    // Randomized traffic, checked every cycle by the compare process.
    for (int n = 0; n < 4000; n++) begin
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_div   = CNT_W'($urandom_range(0, 6));
      cfg_burst = BURST_W'($urandom_range(0, 4));
      start     = ($urandom_range(0, 5) == 0);
      stop      = ($urandom_range(0, 24) == 0);
      cyc();
    end
    cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (4) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_sched_ctrl.md
Name: tick_sched_ctrl

Overview:
- Run-time controller for the divided-tick datapath: a programmable divider that produces one-cycle enable ticks.
- Adds a valid/ready configuration port, start/stop sequencing, finite bursts and glitch-free ratio changes.
- Sits between the register/CPU interface and downstream logic that consumes periodic enables, e.g. sample strobes or baud ticks.

Parameters:
- CNT_W, 16, width of divide-ratio field and internal period counter.
- BURST_W, 8, width of burst-length field and tick counter.
- DEF_DIV, 16, active divide ratio after reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  configuration can be accepted.
- cfg_div  in  CNT_W  requested divide ratio; 0 and 1 both mean a tick every cycle.
- cfg_burst  in  BURST_W  tick count per run; 0 means continuous.
- start  in  1  begin a run (level sampled each edge).
- stop  in  1  abort a run.
- tick  out  1  registered one-cycle enable pulse.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse at the end of a run.
- tick_count  out  BURST_W  ticks issued since the last start; saturates at all-ones.

Behaviour:
- Reset values: tick=0, busy=0, done=0, tick_count=0, cfg_ready=1, state=IDLE, active_div=DEF_DIV, active_burst=0, no pending shadow.
- Reset is asynchronous and clears everything at any point, including mid-run. No tick or done is emitted on reset release.
- FSM states: IDLE, RUN.
- Configuration handshake: a transfer occurs at an edge where cfg_valid && cfg_ready.
  - In IDLE: cfg_ready=1. The transfer loads active_div and active_burst directly.
  - In RUN: cfg_ready=1 only while no shadow update is pending. The transfer writes shadow_div and sets pending; cfg_burst is stored and takes effect at the next start.
  - The pending shadow_div is copied to active_div on the edge where the period counter wraps (count==eff_div-1). This clears pending, so the period in progress is never truncated.
  - A pending shadow still outstanding when the run ends is applied on the IDLE entry edge.
- Effective ratio: eff_div = max(active_div, 1). All compares are at CNT_W width; no overflow is possible.
- IDLE -> RUN: start=1 and stop=0 at edge T.
  - count and tick_count are cleared.
  - busy=1 from T+1.
  - The first tick is high in cycle T+1.
  - Subsequent ticks repeat every eff_div cycles.
- RUN, counting: count increments each cycle and wraps to 0 after eff_div-1. tick is registered high in the cycle following each wrap edge. Each tick increments tick_count.
- RUN -> IDLE, burst complete: active_burst!=0 and the issued tick equals active_burst. On the edge after that tick, busy=0 and done=1 for exactly one cycle.
- RUN -> IDLE, stop: stop=1 at an edge in RUN. busy=0, tick=0 and done=1 in the next cycle. A tick due that same cycle is suppressed.
- Simultaneous events:
  - start in RUN is ignored.
  - start and stop together in IDLE: remain IDLE, no done.
  - stop together with the final burst tick edge: done pulses once only.
  - stop in IDLE: no effect.
- tick_count holds its value in IDLE until the next start.

Optional Feature:
- Macro: TICK_SCHED_PHASE_EN.
- When defined:
  - Adds input cfg_phase [CNT_W], captured with cfg_div on every handshake.
  - On start, count is preloaded so the first tick appears in cycle T+1+phase.
  - phase >= eff_div is clamped to eff_div-1.
  - The period after the first tick is unchanged.
- When undefined:
  - No cfg_phase port.
  - The first tick is always in cycle T+1.

Test Plan:
- Reset release, then start=1 for one cycle at T with DEF_DIV=16 and burst 0 -> tick at T+1, T+17, T+33; busy=1; done never asserts.
- IDLE cfg_div=4, cfg_burst=3, then start -> exactly 3 ticks 4 cycles apart. Next cycle: done=1, busy=0, tick_count=3.
- RUN with div=8; mid-period cfg_div=3 accepted -> current 8-cycle period completes, then ticks 3 apart. cfg_ready=0 from the accept edge until the wrap.
- Drive stop on the edge a tick is due -> no tick; done=1 one cycle later; tick_count unchanged.
- cfg_div=0 and cfg_div=1 -> tick every cycle. start+stop together in IDLE -> stays IDLE, no done.
- Assert rst_n low mid-run -> all outputs 0 immediately. After release, active_div=16 and no spurious tick or done.
